req_priority_encoder: RTL and testbench
=======================================

# req_priority_encoder

Parametrised, registered successor to the 4-input combinational encoder. It latches request pulses from N lines into a pending set and emits one encoded index per transfer over a valid/ready handshake. It supports fixed-priority and round-robin selection, and flags merged (lost) requests. It sits between event sources (interrupt-style pulses, channel done flags) and a single downstream consumer that services one index at a time.

## Interface
- N, default 4: number of request lines; legal range 2..32.
- MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- W, derived localparam, $clog2(N): width of the encoded index. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  request bits. Each cycle a bit is high counts as one request event.
- out_ready  input  1  the consumer accepts out_index this cycle.
- out_valid  output  1  out_index holds an undelivered request.
- out_index  output  W  encoded index of the request being offered.
- pending  output  N  requests captured but not yet loaded into the output register.
- overflow  output  1  sticky flag; set when a request merges into an already-pending bit.

## Operation
- State:
  - pending register P (N bits).
  - output register with out_valid/out_index.
  - round-robin pointer R (W bits, last granted index).
  - overflow flag.
- Candidate set C = P | req_in. Same-cycle requests are visible to selection (bypass).
- load = !out_valid || out_ready, meaning the output register is free or is being drained this cycle.
- On load with C != 0:
  - select index s from C;
  - out_index <= s, out_valid <= 1;
  - in MODE 1, R <= s.
- On load with C == 0: out_valid <= 0, out_index holds its value.
- P_next = C & ~onehot(s) when a selection is loaded, otherwise C.
- Selection rules:
  - MODE 0: lowest set index of C.
  - MODE 1: first set index scanning R+1, R+2, …, wrapping modulo N, ending at R. R itself is eligible last.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_index and out_valid are held stable regardless of new requests.
- Overflow:
  - Set when any bit is high in both req_in and P, and that bit is not the one being loaded this cycle. Such a request is merged and lost.
  - A request for the index currently held in the output register is not an overflow; it becomes a new pending bit.
  - Cleared only by rst.
- pending is P (registered). It does not include same-cycle req_in.

## Timing
- Reset values after an edge with rst=1:
  - P = 0, out_valid = 0, out_index = 0, overflow = 0.
  - R = N-1, so the first round-robin search starts at index 0.
- rst dominates: req_in and out_ready are ignored in the reset cycle. Held output and pending requests are discarded, with no partial transfer.
- Latency: a request that is high before edge t, with the output register free, gives out_valid=1 with that index immediately after edge t (1 cycle).
- Throughput: one index per cycle when out_ready is held high.
- Simultaneous events:
  - A transfer and a new load happen on the same edge, with no bubble.
  - If a req_in bit is high for the index being loaded that cycle, the bit is loaded and cleared. It is not re-pended and not flagged.
- When all N bits are pending with out_ready=1, N consecutive transfers drain P. out_valid falls on the edge after the last transfer if no new requests arrive.

## Test plan
- N=4, MODE=0; after reset, req_in=4'b1010 for one cycle with out_ready=1 → out_index 1 on the next cycle, then 3; out_valid falls after; overflow=0.
- N=4, MODE=0; out_ready=0, req_in=4'b1000 then 4'b0001 → out_index held at 3 until out_ready rises, then 0; pending shows 4'b0001 while stalled.
- N=4, MODE=1; req_in=4'b1111 for one cycle, out_ready=1 → indices 0,1,2,3 on consecutive cycles; then req_in=4'b1001 → 0 (scan wraps from R=3), then 3.
- N=4; stall with P=4'b0100, pulse req_in=4'b0100 → overflow=1 and stays 1; after release, exactly one transfer of index 2.
- Reset mid-operation: P=4'b0110, out_valid=1, assert rst for one cycle with req_in=4'b1111 → all outputs at reset values, pending=0, no transfer.
- N=8, MODE=1, out_ready=1, req_in held at 8'b1000_0001 for 6 cycles → alternates 0,7,0,7,…; overflow stays 0.

Source files
------------

// File: rtl/req_priority_encoder.sv
// Latches request pulses into a pending set and offers one encoded index at a time (fixed or round-robin).
// Latency: a request high before edge t appears on out_index right after edge t when the output is free.
// Backpressure: out_valid/out_index hold while out_ready is low; new requests pend, and repeats of pending bits set overflow.
module req_priority_encoder #(
  parameter  int N    = 4,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_index,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] pend_q;
  logic [W-1:0] rr_ptr;
  logic [N-1:0] cand;
  logic         load;
  logic         found;
  logic [W-1:0] sel;
  logic [N-1:0] sel_oh;
  logic [N-1:0] pend_nxt;
  logic         ovf_hit;

  // Lowest set index; caller only uses the result when c is non-zero.
  function automatic logic [W-1:0] pick_low(input logic [N-1:0] c);
    logic [W-1:0] s;
    logic         f;
    s = '0;
    f = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!f && c[i]) begin
        s = W'(i);
        f = 1'b1;
      end
    end
    return s;
  endfunction

  // First set index scanning r+1 .. r (wrapping), so the last grant is eligible last.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] c, input logic [W-1:0] r);
    logic [W-1:0] s;
    logic         f;
    int           idx;
    s   = '0;
    f   = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r) + k) % N;
      if (!f && c[idx]) begin
        s = W'(idx);
        f = 1'b1;
      end
    end
    return s;
  endfunction

  // Selection over pending plus same-cycle requests, and the next pending/overflow terms.
  always_comb begin
    cand  = pend_q | req_in;
    load  = !out_valid || out_ready;
    found = |cand;
    if (MODE == 0) begin
      sel = pick_low(cand);
    end else begin
      sel = pick_rr(cand, rr_ptr);
    end
    sel_oh   = (load && found) ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
    pend_nxt = cand & ~sel_oh;
    // A repeat of a pending bit is lost unless that bit is the one leaving for the output register.
    ovf_hit  = |(req_in & pend_q & ~sel_oh);
  end

  // State update: reset dominates, otherwise load the output register whenever it is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      overflow  <= 1'b0;
      rr_ptr    <= W'(N - 1);
    end else begin
      pend_q <= pend_nxt;
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
      if (load) begin
        out_valid <= found;
        if (found) begin
          out_index <= sel;
          if (MODE == 1) begin
            rr_ptr <= sel;
          end
        end
      end
    end
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
module tb_req_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: N=4 fixed priority
  logic       rst0, rdy0, vld0, ovf0;
  logic [3:0] req0, pend0;
  logic [1:0] idx0;
  // u1: N=4 round-robin
  logic       rst1, rdy1, vld1, ovf1;
  logic [3:0] req1, pend1;
  logic [1:0] idx1;
  // u2: N=8 round-robin
  logic       rst2, rdy2, vld2, ovf2;
  logic [7:0] req2, pend2;
  logic [2:0] idx2;

  int q0[$];
  int q1[$];
  int q2[$];

  req_priority_encoder #(.N(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst0), .req_in(req0), .out_ready(rdy0),
    .out_valid(vld0), .out_index(idx0), .pending(pend0), .overflow(ovf0)
  );
  req_priority_encoder #(.N(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst1), .req_in(req1), .out_ready(rdy1),
    .out_valid(vld1), .out_index(idx1), .pending(pend1), .overflow(ovf1)
  );
  req_priority_encoder #(.N(8), .MODE(1)) u2 (
    .clk(clk), .rst(rst2), .req_in(req2), .out_ready(rdy2),
    .out_valid(vld2), .out_index(idx2), .pending(pend2), .overflow(ovf2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got transfer of index %0d expected none", nm, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every transfer (valid && ready, not in reset) pops one expected index.
  always @(negedge clk) begin
    if (!rst0 && vld0 && rdy0) begin
      if (q0.size() == 0) extra("u0 xfer", int'(idx0));
      else chk("u0 xfer index", int'(idx0), q0.pop_front());
    end
  end
  always @(negedge clk) begin
    if (!rst1 && vld1 && rdy1) begin
      if (q1.size() == 0) extra("u1 xfer", int'(idx1));
      else chk("u1 xfer index", int'(idx1), q1.pop_front());
    end
  end
  always @(negedge clk) begin
    if (!rst2 && vld2 && rdy2) begin
      if (q2.size() == 0) extra("u2 xfer", int'(idx2));
      else chk("u2 xfer index", int'(idx2), q2.pop_front());
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    req0 = '0;   req1 = '0;   req2 = '0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    tick();
    tick();
    chk("reset out_valid", int'(vld0), 0);
    chk("reset out_index", int'(idx0), 0);
    chk("reset pending", int'(pend0), 0);
    chk("reset overflow", int'(ovf0), 0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Fixed priority: 1010 pulse -> 1 then 3
    rdy0 = 1'b1;
    req0 = 4'b1010;
    q0.push_back(1); q0.push_back(3);
    tick();
    req0 = 4'b0000;
    chk("t1 first valid", int'(vld0), 1);
    chk("t1 first index", int'(idx0), 1);
    chk("t1 pending", int'(pend0), 4'b1000);
    tick();
    chk("t1 second index", int'(idx0), 3);
    tick();
    chk("t1 valid falls", int'(vld0), 0);
    chk("t1 overflow", int'(ovf0), 0);

    // Stall: 1000 then 0001 -> 3 held, then 0
    rdy0 = 1'b0;
    req0 = 4'b1000;
    tick();
    req0 = 4'b0001;
    tick();
    req0 = 4'b0000;
    chk("t2 held index", int'(idx0), 3);
    chk("t2 stalled pending", int'(pend0), 4'b0001);
    tick();
    tick();
    chk("t2 still held valid", int'(vld0), 1);
    chk("t2 still held index", int'(idx0), 3);
    q0.push_back(3); q0.push_back(0);
    rdy0 = 1'b1;
    tick();
    chk("t2 after release index", int'(idx0), 0);
    chk("t2 pending drained", int'(pend0), 0);
    tick();
    tick();
    chk("t2 idle", int'(vld0), 0);

    // Overflow: hold 0 in output, P=0100, pulse 0100 again
    rdy0 = 1'b0;
    req0 = 4'b0101;
    tick();
    chk("t4 pending", int'(pend0), 4'b0100);
    chk("t4 no overflow yet", int'(ovf0), 0);
    req0 = 4'b0100;
    tick();
    req0 = 4'b0000;
    chk("t4 overflow set", int'(ovf0), 1);
    tick();
    chk("t4 overflow sticky", int'(ovf0), 1);
    q0.push_back(0); q0.push_back(2);
    rdy0 = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("t4 idle after drain", int'(vld0), 0);
    chk("t4 overflow still set", int'(ovf0), 1);
    chk("t4 queue empty", q0.size(), 0);

    // Reset mid-operation with requests and ready asserted
    rdy0 = 1'b0;
    req0 = 4'b0111;
    tick();
    req0 = 4'b0000;
    chk("t5 pending before rst", int'(pend0), 4'b0110);
    chk("t5 valid before rst", int'(vld0), 1);
    rst0 = 1'b1;
    req0 = 4'b1111;
    rdy0 = 1'b1;
    tick();
    rst0 = 1'b0;
    req0 = 4'b0000;
    chk("t5 rst out_valid", int'(vld0), 0);
    chk("t5 rst out_index", int'(idx0), 0);
    chk("t5 rst pending", int'(pend0), 0);
    chk("t5 rst overflow", int'(ovf0), 0);
    tick();
    tick();
    chk("t5 stays idle", int'(vld0), 0);

    // Round-robin N=4: 1111 -> 0,1,2,3 then 1001 -> 0,3
    rdy1 = 1'b1;
    req1 = 4'b1111;
    q1.push_back(0); q1.push_back(1); q1.push_back(2); q1.push_back(3);
    tick();
    req1 = 4'b0000;
    chk("t3 first rr index", int'(idx1), 0);
    tick();
    tick();
    tick();
    chk("t3 last rr index", int'(idx1), 3);
    tick();
    chk("t3 drained", int'(vld1), 0);
    req1 = 4'b1001;
    q1.push_back(0); q1.push_back(3);
    tick();
    req1 = 4'b0000;
    chk("t3 wrap index", int'(idx1), 0);
    tick();
    tick();
    chk("t3 wrap drained", int'(vld1), 0);
    chk("t3 no overflow", int'(ovf1), 0);

    // Round-robin N=8: 1000_0001 held for 6 cycles
    rdy2 = 1'b1;
    req2 = 8'b1000_0001;
    for (int i = 0; i < 7; i++) q2.push_back((i % 2 == 0) ? 0 : 7);
    for (int i = 0; i < 6; i++) tick();
    req2 = 8'b0000_0000;
    chk("t6 overflow mid", int'(ovf2), 0);
    tick();
    tick();
    tick();
    chk("t6 idle", int'(vld2), 0);
    chk("t6 overflow", int'(ovf2), 0);

    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    chk("q2 empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
